// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared constants for the pipeline stall/flush control path.
//   - Hazard codes driven by the hazard detection unit.
//   - Stall controller FSM state encoding.
//   - Bundle type for the four pipeline control outputs and a helper that
//     returns the "freeze front end, inject bubble" setting.
package pipeline_pkg;

   // Hazard codes; 2'b10 is reserved and decodes as no hazard.
   localparam logic [1:0] HZ_NONE = 2'b00;
   localparam logic [1:0] HZ_EX   = 2'b01;
   localparam logic [1:0] HZ_MEM  = 2'b11;

   // Stall controller states.
   localparam logic RUN   = 1'b0;
   localparam logic HOLD1 = 1'b1;

   typedef struct packed {
      logic pc_write;
      logic if_id_write;
      logic if_id_flush;
      logic id_ex_bubble;
   } ctrl_t;

   // Front end frozen, ID/EX gets a bubble, no squash.
   function automatic ctrl_t ctrl_stall();
      ctrl_t c;
      c.pc_write     = 1'b0;
      c.if_id_write  = 1'b0;
      c.if_id_flush  = 1'b0;
      c.id_ex_bubble = 1'b1;
      return c;
   endfunction

endpackage

// File: rtl/stall_ctrl_if.sv
// stall_ctrl_if: hazard-unit-to-pipeline control bundle around stall_ctrl.
//   FlushSignal  [1:0]  hazard code from the hazard detection unit
//   BranchTaken         branch resolved taken in decode
//   PCWrite             PC may update
//   IF_ID_Write         IF/ID register may load
//   IF_ID_Flush         IF/ID loads a nop
//   ID_EX_Bubble        ID/EX control fields forced to zero
//   Stalled             controller is holding a multi-cycle stall (debug)
//   StallCycles         saturating count of bubble cycles
//   FlushCycles         saturating count of flush cycles
// Modports: master = hazard side (drives codes), slave = stall_ctrl.
interface stall_ctrl_if #(
   parameter int unsigned CNT_WIDTH = 16
) ();

   logic [1:0]           FlushSignal;
   logic                 BranchTaken;
   logic                 PCWrite;
   logic                 IF_ID_Write;
   logic                 IF_ID_Flush;
   logic                 ID_EX_Bubble;
   logic                 Stalled;
   logic [CNT_WIDTH-1:0] StallCycles;
   logic [CNT_WIDTH-1:0] FlushCycles;

   modport master (
      output FlushSignal,
      output BranchTaken,
      input  PCWrite,
      input  IF_ID_Write,
      input  IF_ID_Flush,
      input  ID_EX_Bubble,
      input  Stalled,
      input  StallCycles,
      input  FlushCycles
   );

   modport slave (
      input  FlushSignal,
      input  BranchTaken,
      output PCWrite,
      output IF_ID_Write,
      output IF_ID_Flush,
      output ID_EX_Bubble,
      output Stalled,
      output StallCycles,
      output FlushCycles
   );

endinterface

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter.
//   Clk    clock, counts on the rising edge
//   Reset  synchronous active-high clear; also forces Count to 0 while high
//   Inc    add one this cycle
//   Count  current value, holds at all-ones
module sat_counter #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Inc,
   output logic [WIDTH-1:0] Count
);

   logic [WIDTH-1:0] r_count;
   logic             w_at_max;

   assign w_at_max = (r_count == {WIDTH{1'b1}});

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_count <= '0;
      end else if (Inc && !w_at_max) begin
         r_count <= r_count + {{(WIDTH-1){1'b0}}, 1'b1};
      end
   end

   // Reads zero during the whole reset pulse, not just after the first edge.
   assign Count = Reset ? '0 : r_count;

endmodule

// File: rtl/stall_ctrl.sv
// stall_ctrl: turns the hazard unit's 2-bit code into pipeline control.
//   Clk    pipeline clock
//   Reset  synchronous active-high reset
//   bus    stall_ctrl_if.slave: FlushSignal/BranchTaken in; PCWrite,
//          IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, Stalled, StallCycles,
//          FlushCycles out
// Control outputs are combinational from the state and current inputs; the
// state register and the two performance counters update on the clock edge.
module stall_ctrl
   import pipeline_pkg::*;
#(
   parameter int unsigned CNT_WIDTH = 16
) (
   input  logic         Clk,
   input  logic         Reset,
   stall_ctrl_if.slave  bus
);

   logic  r_state;
   logic  w_state_d;
   logic  w_hz_ex;
   logic  w_hz_mem;
   ctrl_t w_ctrl;

   assign w_hz_ex  = (bus.FlushSignal == HZ_EX);
   assign w_hz_mem = (bus.FlushSignal == HZ_MEM);

   always_comb begin
      w_ctrl    = ctrl_stall();
      w_state_d = RUN;
      if (Reset) begin
         // Hold the pipeline frozen until reset releases.
         w_state_d = RUN;
      end else if (r_state == HOLD1) begin
         // Second bubble of an EX hazard; inputs are stale here and ignored.
         w_state_d = RUN;
      end else if (w_hz_ex || w_hz_mem) begin
         // Stall wins over a coincident branch: its operands are stale.
         w_state_d = w_hz_ex ? HOLD1 : RUN;
      end else begin
         w_ctrl.pc_write     = 1'b1;
         w_ctrl.if_id_write  = 1'b1;
         w_ctrl.if_id_flush  = bus.BranchTaken;
         w_ctrl.id_ex_bubble = 1'b0;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state <= RUN;
      end else begin
         r_state <= w_state_d;
      end
   end

   assign bus.PCWrite      = w_ctrl.pc_write;
   assign bus.IF_ID_Write  = w_ctrl.if_id_write;
   assign bus.IF_ID_Flush  = w_ctrl.if_id_flush;
   assign bus.ID_EX_Bubble = w_ctrl.id_ex_bubble;
   assign bus.Stalled      = !Reset && (r_state == HOLD1);

   sat_counter #(
      .WIDTH (CNT_WIDTH)
   ) u_stall_cnt (
      .Clk   (Clk),
      .Reset (Reset),
      .Inc   (w_ctrl.id_ex_bubble),
      .Count (bus.StallCycles)
   );

   sat_counter #(
      .WIDTH (CNT_WIDTH)
   ) u_flush_cnt (
      .Clk   (Clk),
      .Reset (Reset),
      .Inc   (w_ctrl.if_id_flush),
      .Count (bus.FlushCycles)
   );

endmodule

// File: tb/tb_stall_ctrl.sv
// tb_stall_ctrl: directed bench for stall_ctrl. Each step drives one cycle of
// inputs and pushes the expected outputs; at the falling edge the entry is
// popped and compared. A second instance with 4-bit counters covers
// saturation and is only compared in that phase.
module tb_stall_ctrl;
   import pipeline_pkg::*;

   logic Clk = 1'b0;
   logic Reset;
   int   total = 0;
   int   bad   = 0;

   typedef struct {
      logic pcw;
      logic ifw;
      logic fl;
      logic bub;
      logic st;
      int   sc;
      int   fc;
      int   sc4;
   } exp_t;

   exp_t sb_q[$];

   stall_ctrl_if #(.CNT_WIDTH(16)) ifc ();
   stall_ctrl_if #(.CNT_WIDTH(4))  ifc4 ();

   stall_ctrl #(.CNT_WIDTH(16)) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (ifc.slave)
   );

   stall_ctrl #(.CNT_WIDTH(4)) dut4 (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (ifc4.slave)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step(input logic rst, input logic [1:0] fs, input logic bt,
                       input logic pcw, input logic ifw, input logic fl,
                       input logic bub, input logic st, input int sc, input int fc,
                       input int sc4 = -1);
      exp_t e;
      Reset            = rst;
      ifc.FlushSignal  = fs;
      ifc.BranchTaken  = bt;
      ifc4.FlushSignal = fs;
      ifc4.BranchTaken = bt;
      e.pcw = pcw; e.ifw = ifw; e.fl = fl; e.bub = bub; e.st = st;
      e.sc = sc; e.fc = fc; e.sc4 = sc4;
      sb_q.push_back(e);
      @(negedge Clk);
      e = sb_q.pop_front();
      chk("PCWrite",      32'(ifc.PCWrite),      32'(e.pcw));
      chk("IF_ID_Write",  32'(ifc.IF_ID_Write),  32'(e.ifw));
      chk("IF_ID_Flush",  32'(ifc.IF_ID_Flush),  32'(e.fl));
      chk("ID_EX_Bubble", 32'(ifc.ID_EX_Bubble), 32'(e.bub));
      chk("Stalled",      32'(ifc.Stalled),      32'(e.st));
      chk("StallCycles",  32'(ifc.StallCycles),  e.sc);
      chk("FlushCycles",  32'(ifc.FlushCycles),  e.fc);
      if (e.sc4 >= 0) chk("StallCycles4", 32'(ifc4.StallCycles), e.sc4);
      @(posedge Clk);
      #1;
   endtask

   // One reset cycle: front end frozen, bubble selected, everything else 0.
   task automatic rst_step();
      step(1'b1, HZ_NONE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
   endtask

   // Free-running cycle with no hazard and no branch.
   task automatic run_step(input int sc, input int fc);
      step(1'b0, HZ_NONE, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, sc, fc);
   endtask

   initial begin
      // Reset held 3 cycles, then normal flow.
      for (int i = 0; i < 3; i++) rst_step();
      run_step(0, 0);

      // EX hazard for one cycle: two bubbles, Stalled on the second.
      step(1'b0, HZ_EX,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
      step(1'b0, HZ_NONE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1, 0);
      run_step(2, 0);

      // MEM hazard held 3 cycles: one bubble per cycle, never Stalled.
      rst_step();
      for (int i = 0; i < 3; i++)
         step(1'b0, HZ_MEM, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, i, 0);
      run_step(3, 0);

      // Branch coinciding with an EX hazard resolves only after the stall.
      rst_step();
      step(1'b0, HZ_EX,   1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
      step(1'b0, HZ_EX,   1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1, 0);
      step(1'b0, HZ_NONE, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2, 0);
      run_step(2, 1);
      // Branch under a MEM hazard is suppressed; reserved code acts as none.
      step(1'b0, HZ_MEM,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2, 1);
      step(1'b0, 2'b10,   1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3, 1);
      run_step(3, 2);

      // Saturation: 4-bit counter tops out at 15, 16-bit keeps counting.
      rst_step();
      for (int i = 0; i < 20; i++)
         step(1'b0, HZ_MEM, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, i, 0, (i < 15) ? i : 15);
      step(1'b0, HZ_NONE, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 20, 0, 15);
      step(1'b0, HZ_NONE, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 20, 0, 15);

      // Reset during HOLD1 abandons the second bubble.
      rst_step();
      step(1'b0, HZ_EX, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
      rst_step();
      run_step(0, 0);
      run_step(0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
